// File: rtl/cpu_pkg.sv
// Encodings shared by the sequencing controller, the datapath and the benches:
// FSM states, opcode fields, ALU/shift/writeback selects and the registered control bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        GET_A,
        GET_B,
        COMPUTE,
        WR_REG,
        WR_IMM
    } state_e;

    typedef enum logic [2:0] {
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN,
        CLS_ILLEGAL
    } instr_class_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

    localparam logic [1:0] WB_C     = 2'b00;
    localparam logic [1:0] WB_PC    = 2'b01;
    localparam logic [1:0] WB_IMM8  = 2'b10;
    localparam logic [1:0] WB_MDATA = 2'b11;

    typedef struct packed {
        logic       waiting;
        logic [2:0] w_addr;
        logic [2:0] r_addr;
        logic       w_en;
        logic [1:0] wb_sel;
        logic       en_a;
        logic       en_b;
        logic       en_c;
        logic       en_status;
        logic       sel_a;
        logic       sel_b;
        logic [1:0] shift_op;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_decoder.sv
// Combinational instruction-register decode: field extraction, instruction class and
// the two sign-extended immediates.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0]  ir,
    output logic [2:0]   rn,
    output logic [2:0]   rd,
    output logic [2:0]   rm,
    output logic [1:0]   sh,
    output instr_class_e cls,
    output logic [15:0]  sximm8,
    output logic [15:0]  sximm5
);

    logic [2:0] opcode;
    logic [1:0] op;

    always_comb begin
        opcode = ir[15:13];
        op     = ir[12:11];
        rn     = ir[10:8];
        rd     = ir[7:5];
        sh     = ir[4:3];
        rm     = ir[2:0];
        sximm8 = sext8(ir[7:0]);
        sximm5 = sext5(ir[4:0]);
        cls    = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM) begin
                cls = CLS_MOV_IMM;
            end else if (op == OP_MOV_REG) begin
                cls = CLS_MOV_REG;
            end
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
    end

endmodule

// File: rtl/cpu_controller.sv
// Sequencing FSM for the 16-bit datapath. Control outputs are registered from the next
// state, so each output is valid for exactly the cycle its state is occupied.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter bit STATUS_ALL  = 1'b0,
    parameter bit ILLEGAL_NOP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] instr,
    output logic        waiting,
    output logic        illegal,
    output logic [2:0]  w_addr,
    output logic [2:0]  r_addr,
    output logic        w_en,
    output logic [1:0]  wb_sel,
    output logic        en_A,
    output logic        en_B,
    output logic        en_C,
    output logic        en_status,
    output logic        sel_A,
    output logic        sel_B,
    output logic [1:0]  shift_op,
    output logic [1:0]  ALU_op,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    // WAIT idle | DECODE classify | GET_A/GET_B load A/B | COMPUTE ALU into C | WR_REG/WR_IMM write back
    state_e       state_q, state_d;
    logic [15:0]  ir_q, ir_d;
    logic         illegal_q, illegal_d;
    ctrl_t        ctrl_q, ctrl_d;

    logic [2:0]   rn, rd, rm;
    logic [1:0]   sh;
    instr_class_e cls;

    // IR only changes on the WAIT->DECODE edge, and no state entered from WAIT needs IR
    // fields, so decoding the current IR is enough to build the next-state outputs.
    instr_decoder u_dec (
        .ir     (ir_q),
        .rn     (rn),
        .rd     (rd),
        .rm     (rm),
        .sh     (sh),
        .cls    (cls),
        .sximm8 (sximm8),
        .sximm5 (sximm5)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        illegal_d = illegal_q;
        case (state_q)
            WAIT: begin
                if (start) begin
                    state_d   = DECODE;
                    ir_d      = instr;
                    illegal_d = 1'b0;
                end
            end
            DECODE: begin
                case (cls)
                    CLS_MOV_IMM:               state_d = WR_IMM;
                    CLS_MOV_REG, CLS_MVN:      state_d = GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND: state_d = GET_A;
                    default: begin
                        state_d   = WAIT;
                        illegal_d = ~ILLEGAL_NOP;
                    end
                endcase
            end
            GET_A:   state_d = GET_B;
            GET_B:   state_d = COMPUTE;
            COMPUTE: state_d = (cls == CLS_CMP) ? WAIT : WR_REG;
            default: state_d = WAIT;
        endcase
    end

    always_comb begin
        ctrl_d         = '0;
        ctrl_d.waiting = (state_d == WAIT);
        case (state_d)
            GET_A: begin
                ctrl_d.r_addr = rn;
                ctrl_d.en_a   = 1'b1;
            end
            GET_B: begin
                ctrl_d.r_addr = rm;
                ctrl_d.en_b   = 1'b1;
            end
            COMPUTE: begin
                ctrl_d.en_c      = 1'b1;
                ctrl_d.shift_op  = sh;
                ctrl_d.en_status = STATUS_ALL || (cls == CLS_CMP);
                case (cls)
                    CLS_CMP: ctrl_d.alu_op = ALU_SUB;
                    CLS_AND: ctrl_d.alu_op = ALU_AND;
                    CLS_MVN: ctrl_d.alu_op = ALU_NOT;
                    CLS_MOV_REG: begin
                        ctrl_d.alu_op = ALU_ADD;
                        ctrl_d.sel_a  = 1'b1;
                    end
                    default: ctrl_d.alu_op = ALU_ADD;
                endcase
            end
            WR_REG: begin
                ctrl_d.w_addr = rd;
                ctrl_d.wb_sel = WB_C;
                ctrl_d.w_en   = 1'b1;
            end
            WR_IMM: begin
                ctrl_d.w_addr = rn;
                ctrl_d.wb_sel = WB_IMM8;
                ctrl_d.w_en   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WAIT;
            ir_q           <= '0;
            illegal_q      <= 1'b0;
            ctrl_q         <= '0;
            ctrl_q.waiting <= 1'b1;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign waiting   = ctrl_q.waiting;
    assign illegal   = illegal_q;
    assign w_addr    = ctrl_q.w_addr;
    assign r_addr    = ctrl_q.r_addr;
    assign w_en      = ctrl_q.w_en;
    assign wb_sel    = ctrl_q.wb_sel;
    assign en_A      = ctrl_q.en_a;
    assign en_B      = ctrl_q.en_b;
    assign en_C      = ctrl_q.en_c;
    assign en_status = ctrl_q.en_status;
    assign sel_A     = ctrl_q.sel_a;
    assign sel_B     = ctrl_q.sel_b;
    assign shift_op  = ctrl_q.shift_op;
    assign ALU_op    = ctrl_q.alu_op;

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: a behavioural datapath follows the control outputs; expected
// writes and per-instruction results are queued at issue time and checked by a monitor.
module tb_cpu_controller;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] instr;
    logic        waiting, illegal, w_en, en_A, en_B, en_C, en_status, sel_A, sel_B;
    logic [2:0]  w_addr, r_addr;
    logic [1:0]  wb_sel, shift_op, ALU_op;
    logic [15:0] sximm8, sximm5;

    cpu_controller #(.STATUS_ALL(1'b0), .ILLEGAL_NOP(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr),
        .waiting(waiting), .illegal(illegal), .w_addr(w_addr), .r_addr(r_addr),
        .w_en(w_en), .wb_sel(wb_sel), .en_A(en_A), .en_B(en_B), .en_C(en_C),
        .en_status(en_status), .sel_A(sel_A), .sel_B(sel_B), .shift_op(shift_op),
        .ALU_op(ALU_op), .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    // Behavioural datapath driven by the controller
    logic [15:0] rf [0:7] = '{default: 16'h0000};
    logic [15:0] a_r = '0, b_r = '0, c_r = '0;
    logic        z_r = 1'b0, n_r = 1'b0, v_r = 1'b0;
    logic [15:0] shifted, ain, bin, alu_out, wdata;
    logic        alu_v;

    always_comb begin
        case (shift_op)
            SH_LSL:  shifted = {b_r[14:0], 1'b0};
            SH_LSR:  shifted = {1'b0, b_r[15:1]};
            SH_ASR:  shifted = {b_r[15], b_r[15:1]};
            default: shifted = b_r;
        endcase
        ain   = (sel_A === 1'b1) ? 16'h0000 : a_r;
        bin   = (sel_B === 1'b1) ? sximm5 : shifted;
        alu_v = 1'b0;
        case (ALU_op)
            ALU_SUB: begin
                alu_out = ain - bin;
                alu_v   = (ain[15] != bin[15]) && (alu_out[15] != ain[15]);
            end
            ALU_AND: alu_out = ain & bin;
            ALU_NOT: alu_out = ~bin;
            default: alu_out = ain + bin;
        endcase
        case (wb_sel)
            WB_C:    wdata = c_r;
            WB_IMM8: wdata = sximm8;
            default: wdata = 16'h0000;
        endcase
    end

    always @(posedge clk) begin
        if (en_A === 1'b1) a_r <= rf[r_addr];
        if (en_B === 1'b1) b_r <= rf[r_addr];
        if (en_C === 1'b1) c_r <= alu_out;
        if (en_status === 1'b1) {z_r, n_r, v_r} <= {alu_out == 16'h0000, alu_out[15], alu_v};
        if (w_en === 1'b1) rf[w_addr] <= wdata;
    end

    // Scoreboard
    typedef struct {
        int          lat;
        int          nwr;
        logic [15:0] dout;
        bit          chk_flags;
        logic [2:0]  flags;
    } done_t;

    logic [20:0] exp_wr_q [$];
    done_t       exp_done_q [$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic exp_write(input logic [2:0] addr, input logic [1:0] sel, input logic [15:0] data);
        exp_wr_q.push_back({addr, sel, data});
    endtask

    task automatic exp_done(input int lat, input int nwr, input logic [15:0] dout,
                            input bit chk, input logic [2:0] flags);
        done_t d;
        d.lat = lat; d.nwr = nwr; d.dout = dout; d.chk_flags = chk; d.flags = flags;
        exp_done_q.push_back(d);
    endtask

    // Monitor: latency counted in edges, the accepting edge being edge 1
    int cnt = 0;
    bit rst_at_edge = 1'b0;
    bit acc_at_edge = 1'b0;

    always @(posedge clk) begin
        rst_at_edge <= (rst === 1'b1);
        acc_at_edge <= (waiting === 1'b1 && start === 1'b1 && rst !== 1'b1);
        if (waiting === 1'b1 && start === 1'b1 && rst !== 1'b1) cnt <= 1;
        else cnt <= cnt + 1;
    end

    initial begin
        logic [20:0] e;
        done_t       d;
        int          nwr;
        logic        waiting_prev;
        nwr = 0;
        waiting_prev = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (acc_at_edge) nwr = 0;
            if (w_en === 1'b1) begin
                nwr++;
                if (exp_wr_q.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    e = exp_wr_q.pop_front();
                    check("w_addr", 32'(w_addr), 32'(e[20:18]));
                    check("wb_sel", 32'(wb_sel), 32'(e[17:16]));
                    check("w_data", 32'(wdata), 32'(e[15:0]));
                end
            end
            if (waiting === 1'b1 && waiting_prev !== 1'b1 && !rst_at_edge) begin
                if (exp_done_q.size() == 0) begin
                    fail_now("unexpected_completion");
                end else begin
                    d = exp_done_q.pop_front();
                    check("latency", 32'(cnt), 32'(d.lat));
                    check("write_count", 32'(nwr), 32'(d.nwr));
                    check("datapath_out", 32'(c_r), 32'(d.dout));
                    if (d.chk_flags) check("flags_ZNV", 32'({z_r, n_r, v_r}), 32'(d.flags));
                end
            end
            waiting_prev = waiting;
        end
    end

    task automatic issue(input logic [15:0] ins);
        int g = 0;
        while (waiting !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) fail_now("issue_timeout");
        instr = ins;
        start = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int g = 0;
        while ((exp_wr_q.size() != 0 || exp_done_q.size() != 0 || waiting !== 1'b1) && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) fail_now("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst   = 1'b1;
        start = 1'b0;
        instr = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_waiting", 32'(waiting), 32'd1);
        check("rst_w_en", 32'(w_en), 32'd0);
        check("rst_en_A", 32'(en_A), 32'd0);
        check("rst_en_B", 32'(en_B), 32'd0);
        check("rst_en_C", 32'(en_C), 32'd0);
        check("rst_en_status", 32'(en_status), 32'd0);
        check("rst_sximm8", 32'(sximm8), 32'h0);
        check("rst_illegal", 32'(illegal), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // MOV R2,#1 alone
        exp_write(3'd2, WB_IMM8, 16'h0001); exp_done(3, 1, 16'h0000, 1'b0, 3'b000);
        issue(16'hD201);
        start = 1'b0;
        drain();

        // back-to-back chain with start held high
        exp_write(3'd2, WB_IMM8, 16'h0001); exp_done(3, 1, 16'h0000, 1'b0, 3'b000);
        issue(16'hD201);
        exp_write(3'd3, WB_IMM8, 16'h0003); exp_done(3, 1, 16'h0000, 1'b0, 3'b000);
        issue(16'hD303);
        exp_write(3'd5, WB_C, 16'h0004);    exp_done(6, 1, 16'h0004, 1'b0, 3'b000);
        issue(16'hA2A3);
        exp_done(5, 0, 16'hFFFB, 1'b1, 3'b010);
        issue(16'hAA0B);
        exp_write(3'd4, WB_IMM8, 16'hFFFF); exp_done(3, 1, 16'hFFFB, 1'b0, 3'b000);
        issue(16'hD4FF);
        exp_write(3'd6, WB_C, 16'h0000);    exp_done(5, 1, 16'h0000, 1'b0, 3'b000);
        issue(16'hB8C4);
        exp_write(3'd1, WB_C, 16'h0006);    exp_done(5, 1, 16'h0006, 1'b0, 3'b000);
        issue(16'hC02B);
        exp_write(3'd0, WB_C, 16'h0003);    exp_done(6, 1, 16'h0003, 1'b0, 3'b000);
        issue(16'hB304);
        start = 1'b0;
        drain();

        // reset in GET_B of ADD R5,R4,R3 drops the write
        issue(16'hA4A3);
        start = 1'b0;
        g = 0;
        while (en_B !== 1'b1 && g < 10) begin
            @(negedge clk);
            g++;
        end
        if (g >= 10) fail_now("wait_get_b_timeout");
        rst = 1'b1;
        @(negedge clk);
        check("midrst_waiting", 32'(waiting), 32'd1);
        check("midrst_en_B", 32'(en_B), 32'd0);
        check("midrst_w_en", 32'(w_en), 32'd0);
        check("midrst_en_C", 32'(en_C), 32'd0);
        check("midrst_sximm8", 32'(sximm8), 32'h0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("r5_unchanged", 32'(rf[5]), 32'h0004);

        // start pulse while busy is ignored
        exp_write(3'd1, WB_IMM8, 16'h0005); exp_done(3, 1, 16'h0003, 1'b0, 3'b000);
        issue(16'hD105);
        instr = 16'hD7AA;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("r7_untouched", 32'(rf[7]), 32'h0000);
        check("r1_value", 32'(rf[1]), 32'h0005);

        // undefined opcode goes straight back to WAIT
        exp_done(2, 0, 16'h0003, 1'b0, 3'b000);
        issue(16'h0000);
        start = 1'b0;
        drain();
        check("illegal_nop", 32'(illegal), 32'd0);
        repeat (2) @(negedge clk);
        check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
